cla_lookahead_pipe: RTL

- Pipelined carry-lookahead generator for a row of per-bit adder cells.
- Consumes the per-bit propagate (p = a^b) and generate (g = a&b) vectors those cells produce, plus a carry-in.
- Returns the carry into every bit position, the final sum, the carry-out and the block-level P/G.
- Two-stage pipeline with valid/ready handshake on both sides, so it drops into the multi-bit adder datapath with backpressure.

---
 rtl/cla_pkg.sv | 55 +++++
 rtl/cla_group_unit.sv | 34 +++
 rtl/cla_lookahead_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared widths, the per-bit propagate/generate pair and the lookahead
// equations used by the group units of cla_lookahead_pipe.
package cla_pkg;

  localparam int unsigned CLA_WIDTH     = 16;
  localparam int unsigned CLA_GROUP     = 4;
  localparam int unsigned CLA_MAX_GROUP = 8;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Flat OR-of-ANDs carries c[0..n] for the low n bits of a slice; upper carries read 0.
  function automatic logic [CLA_MAX_GROUP:0] lookahead_carries(
    input logic                     cin,
    input logic [CLA_MAX_GROUP-1:0] p,
    input logic [CLA_MAX_GROUP-1:0] g,
    input int                       n
  );
    logic [CLA_MAX_GROUP:0] c;
    logic                   term;
    logic                   prod;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(CLA_MAX_GROUP); i++) begin
      term = 1'b0;
      prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        term = term | (g[j] & prod);
        prod = prod & p[j];
      end
      if (i < n) c[i+1] = term | (prod & cin);
    end
    return c;
  endfunction

  // Group propagate/generate over the low n bits of a slice.
  function automatic pg_t group_pg(
    input logic [CLA_MAX_GROUP-1:0] p,
    input logic [CLA_MAX_GROUP-1:0] g,
    input int                       n
  );
    pg_t                    r;
    logic [CLA_MAX_GROUP:0] c;
    c   = lookahead_carries(1'b0, p, g, n);
    r.g = c[n];
    r.p = 1'b1;
    for (int i = 0; i < int'(CLA_MAX_GROUP); i++) begin
      if (i < n) r.p = r.p & p[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_group_unit.sv
// One lookahead group: carries into each bit of the slice from the group
// carry-in, plus the group propagate/generate.
module cla_group_unit
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             cin,
  output logic [GROUP-1:0] carry,
  output logic             gp,
  output logic             gg
);

  localparam int unsigned PAD = CLA_MAX_GROUP;

  logic [PAD-1:0]     p_ext;
  logic [PAD-1:0]     g_ext;
  logic [PAD:0]       c_all;
  logic [PAD-GROUP:0] c_hi_unused;
  pg_t                grp;

  assign p_ext = PAD'(p);
  assign g_ext = PAD'(g);

  assign c_all                = lookahead_carries(cin, p_ext, g_ext, int'(GROUP));
  assign {c_hi_unused, carry} = c_all;

  assign grp = group_pg(p_ext, g_ext, int'(GROUP));
  assign gp  = grp.p;
  assign gg  = grp.g;

endmodule

// File: rtl/cla_lookahead_pipe.sv
// Two-stage carry-lookahead generator with valid/ready on both sides:
// stage 1 forms group P/G, stage 2 forms group and bit carries and the sum.
module cla_lookahead_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = CLA_WIDTH,
  parameter int unsigned GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_in,
  input  logic [WIDTH-1:0] g_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             blk_p,
  output logic             blk_g
);

  localparam int unsigned NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || GROUP < 2 || GROUP > CLA_MAX_GROUP) begin : g_param_check
    $error("cla_lookahead_pipe: WIDTH must be a multiple of GROUP and GROUP must be 2..8");
  end

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic             s1_cin;
  logic [NG-1:0]    s1_gp;
  logic [NG-1:0]    s1_gg;

  logic [NG-1:0]    gp_c;
  logic [NG-1:0]    gg_c;
  logic [WIDTH-1:0] s1_c_unused;
  logic [NG:0]      grp_c;
  logic             blk_g_c;
  logic [WIDTH-1:0] carry_c;
  logic [NG-1:0]    s2_gp_unused;
  logic [NG-1:0]    s2_gg_unused;
  logic             term;
  logic             prod;

  // A stage may load when it is empty or the stage after it is moving.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group_unit #(.GROUP(GROUP)) u_s1 (
      .p     (p_in[k*GROUP +: GROUP]),
      .g     (g_in[k*GROUP +: GROUP]),
      .cin   (1'b0),
      .carry (s1_c_unused[k*GROUP +: GROUP]),
      .gp    (gp_c[k]),
      .gg    (gg_c[k])
    );

    cla_group_unit #(.GROUP(GROUP)) u_s2 (
      .p     (s1_p[k*GROUP +: GROUP]),
      .g     (s1_g[k*GROUP +: GROUP]),
      .cin   (grp_c[k]),
      .carry (carry_c[k*GROUP +: GROUP]),
      .gp    (s2_gp_unused[k]),
      .gg    (s2_gg_unused[k])
    );
  end

  // Group carries as a flat lookahead over the registered GP/GG; blk_g is the cin=0 term.
  always_comb begin
    grp_c    = '0;
    blk_g_c  = 1'b0;
    term     = 1'b0;
    prod     = 1'b1;
    grp_c[0] = s1_cin;
    for (int k = 0; k < int'(NG); k++) begin
      term = 1'b0;
      prod = 1'b1;
      for (int j = k; j >= 0; j--) begin
        term = term | (s1_gg[j] & prod);
        prod = prod & s1_gp[j];
      end
      grp_c[k+1] = term | (prod & s1_cin);
      if (k == int'(NG) - 1) blk_g_c = term;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_cin   <= 1'b0;
      s1_gp    <= '0;
      s1_gg    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p   <= p_in;
        s1_g   <= g_in;
        s1_cin <= cin;
        s1_gp  <= gp_c;
        s1_gg  <= gg_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      carry    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      blk_p    <= 1'b0;
      blk_g    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        carry <= carry_c;
        sum   <= s1_p ^ carry_c;
        cout  <= grp_c[NG];
        blk_p <= &s1_gp;
        blk_g <= blk_g_c;
      end
    end
  end

endmodule
